obi_mmap_decoder: RTL and testbench

- Single-master to multi-slave OBI address decoder and response router, sitting directly downstream of the core data port and upstream of the peripheral slaves.
- Decodes each request against the PULPissimo-like memory map and forwards it to exactly one slave.
- Tracks outstanding transactions so responses return to the master in order.
- Unmapped addresses are absorbed by an internal error slave, and decode errors are counted.

---
 rtl/obi_mmap_decoder.sv | 139 +++++++++++++
 tb/tb_obi_mmap_decoder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/obi_mmap_decoder.sv
// OBI single-master to multi-slave address decoder with in-order response routing.
// Unmapped requests complete on an internal error slave and are counted.
module obi_mmap_decoder #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [31:0] ERR_RDATA       = 32'hBADC_AB1E
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         m_req_i,
    output logic         m_gnt_o,
    input  logic [31:0]  m_addr_i,
    input  logic         m_we_i,
    input  logic [3:0]   m_be_i,
    input  logic [31:0]  m_wdata_i,
    output logic         m_rvalid_o,
    output logic [31:0]  m_rdata_o,
    output logic         m_err_o,
    output logic [4:0]   s_req_o,
    output logic [31:0]  s_addr_o,
    output logic         s_we_o,
    output logic [3:0]   s_be_o,
    output logic [31:0]  s_wdata_o,
    input  logic [4:0]   s_gnt_i,
    input  logic [4:0]   s_rvalid_i,
    input  logic [159:0] s_rdata_i,
    input  logic [4:0]   s_err_i,
    output logic [15:0]  dec_err_cnt_o
);

    localparam logic [2:0] TGT_ERR = 3'd5;
    localparam logic [1:0] LAST_PTR = 2'(MAX_OUTSTANDING - 1);
    localparam logic [2:0] MAX_CNT = 3'(MAX_OUTSTANDING);

    logic [2:0]  r_fifo [4];
    logic [1:0]  r_wr_ptr;
    logic [1:0]  r_rd_ptr;
    logic [2:0]  r_count;
    logic [2:0]  r_last;
    logic [15:0] r_err_cnt;

    logic [2:0]  w_tgt;
    logic [2:0]  w_head;
    logic        w_issue;
    logic        w_slv_gnt;
    logic        w_push;
    logic        w_pop;

    always_comb begin
        w_tgt = TGT_ERR;
        if (m_addr_i <= 32'h003F_FFFF)
            w_tgt = 3'd0;
        else if (m_addr_i >= 32'h1A00_0000 && m_addr_i <= 32'h1A0F_FFFF)
            w_tgt = 3'd1;
        else if (m_addr_i >= 32'h1A10_0000 && m_addr_i <= 32'h1A11_0FFF)
            w_tgt = 3'd2;
        else if (m_addr_i >= 32'h1A33_0000 && m_addr_i <= 32'h1A33_000F)
            w_tgt = 3'd3;
        else if (m_addr_i >= 32'h1A44_0000 && m_addr_i <= 32'h1A44_0003)
            w_tgt = 3'd4;
    end

    // Only one target may be in flight at a time so responses stay ordered.
    assign w_issue = !rst_i && (r_count < MAX_CNT)
                   && (r_count == 3'd0 || w_tgt == r_last);

    always_comb begin
        s_req_o   = '0;
        w_slv_gnt = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (w_tgt == 3'(k)) begin
                s_req_o[k] = m_req_i & w_issue;
                w_slv_gnt  = s_gnt_i[k];
            end
        end
        if (w_tgt == TGT_ERR)
            w_slv_gnt = 1'b1;
    end

    assign m_gnt_o = m_req_i & w_issue & w_slv_gnt;
    assign w_push  = m_gnt_o;

    assign s_addr_o  = m_addr_i;
    assign s_we_o    = m_we_i;
    assign s_be_o    = m_be_i;
    assign s_wdata_o = m_wdata_i;

    always_comb begin
        w_head     = r_fifo[r_rd_ptr];
        m_rvalid_o = 1'b0;
        m_rdata_o  = '0;
        m_err_o    = 1'b0;
        if (r_count != 3'd0 && !rst_i) begin
            if (w_head == TGT_ERR) begin
                m_rvalid_o = 1'b1;
                m_rdata_o  = ERR_RDATA;
                m_err_o    = 1'b1;
            end else begin
                for (int k = 0; k < 5; k++) begin
                    if (w_head == 3'(k) && s_rvalid_i[k]) begin
                        m_rvalid_o = 1'b1;
                        m_rdata_o  = s_rdata_i[32*k +: 32];
                        m_err_o    = s_err_i[k];
                    end
                end
            end
        end
    end

    assign w_pop = m_rvalid_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 4; i++)
                r_fifo[i] <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_last    <= '0;
            r_err_cnt <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= w_tgt;
                r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? 2'd0 : r_wr_ptr + 2'd1;
                r_last   <= w_tgt;
                if (w_tgt == TGT_ERR && r_err_cnt != 16'hFFFF)
                    r_err_cnt <= r_err_cnt + 16'd1;
            end
            if (w_pop)
                r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? 2'd0 : r_rd_ptr + 2'd1;
            if (w_push && !w_pop)
                r_count <= r_count + 3'd1;
            else if (!w_push && w_pop)
                r_count <= r_count - 3'd1;
        end
    end

    assign dec_err_cnt_o = r_err_cnt;

endmodule

// File: tb/tb_obi_mmap_decoder.sv
// Directed bench for obi_mmap_decoder: decode, ordering, blocking,
// reset drop and error counter saturation.
module tb_obi_mmap_decoder;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         m_req_i;
    logic         m_gnt_o;
    logic [31:0]  m_addr_i;
    logic         m_we_i;
    logic [3:0]   m_be_i;
    logic [31:0]  m_wdata_i;
    logic         m_rvalid_o;
    logic [31:0]  m_rdata_o;
    logic         m_err_o;
    logic [4:0]   s_req_o;
    logic [31:0]  s_addr_o;
    logic         s_we_o;
    logic [3:0]   s_be_o;
    logic [31:0]  s_wdata_o;
    logic [4:0]   s_gnt_i;
    logic [4:0]   s_rvalid_i;
    logic [159:0] s_rdata_i;
    logic [4:0]   s_err_i;
    logic [15:0]  dec_err_cnt_o;

    int n_chk = 0;
    int n_err = 0;

    obi_mmap_decoder dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m_req_i(m_req_i), .m_gnt_o(m_gnt_o),
        .m_addr_i(m_addr_i), .m_we_i(m_we_i),
        .m_be_i(m_be_i), .m_wdata_i(m_wdata_i),
        .m_rvalid_o(m_rvalid_o), .m_rdata_o(m_rdata_o),
        .m_err_o(m_err_o), .s_req_o(s_req_o),
        .s_addr_o(s_addr_o), .s_we_o(s_we_o),
        .s_be_o(s_be_o), .s_wdata_o(s_wdata_o),
        .s_gnt_i(s_gnt_i), .s_rvalid_i(s_rvalid_i),
        .s_rdata_i(s_rdata_i), .s_err_i(s_err_i),
        .dec_err_cnt_o(dec_err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    logic [31:0] bnd_addr [9];
    logic [4:0]  bnd_req  [9];
    logic        bnd_gnt  [9];

    initial begin
        bnd_addr[0] = 32'h003F_FFFF; bnd_req[0] = 5'b00001; bnd_gnt[0] = 1;
        bnd_addr[1] = 32'h0040_0000; bnd_req[1] = 5'b00000; bnd_gnt[1] = 1;
        bnd_addr[2] = 32'h1A11_0FFF; bnd_req[2] = 5'b00100; bnd_gnt[2] = 1;
        bnd_addr[3] = 32'h1A11_1000; bnd_req[3] = 5'b00000; bnd_gnt[3] = 1;
        bnd_addr[4] = 32'h1A33_0010; bnd_req[4] = 5'b00000; bnd_gnt[4] = 1;
        bnd_addr[5] = 32'h1A00_0000; bnd_req[5] = 5'b00010; bnd_gnt[5] = 1;
        bnd_addr[6] = 32'h1A10_0000; bnd_req[6] = 5'b00100; bnd_gnt[6] = 1;
        bnd_addr[7] = 32'h1A44_0003; bnd_req[7] = 5'b10000; bnd_gnt[7] = 1;
        bnd_addr[8] = 32'h1A44_0004; bnd_req[8] = 5'b00000; bnd_gnt[8] = 1;

        rst_i = 1; m_req_i = 0; m_addr_i = 0; m_we_i = 0;
        m_be_i = 4'hF; m_wdata_i = 32'hCAFE_0001;
        s_gnt_i = 5'h1F; s_rvalid_i = 0; s_rdata_i = '0; s_err_i = 0;
        step(); step();
        rst_i = 0;
        #1;
        chk("rst_gnt", 32'(m_gnt_o), 0);
        chk("rst_sreq", 32'(s_req_o), 0);
        chk("rst_rvalid", 32'(m_rvalid_o), 0);
        chk("rst_rdata", m_rdata_o, 0);
        chk("rst_err", 32'(m_err_o), 0);
        chk("rst_cnt", 32'(dec_err_cnt_o), 0);

        // SRAM read, response two cycles after grant
        m_req_i = 1; m_addr_i = 32'h0000_0100; #1;
        chk("sram_sreq", 32'(s_req_o), 32'b00001);
        chk("sram_gnt", 32'(m_gnt_o), 1);
        chk("bcast_addr", s_addr_o, 32'h0000_0100);
        chk("bcast_wdata", s_wdata_o, 32'hCAFE_0001);
        step(); m_req_i = 0; #1;
        chk("sram_wait", 32'(m_rvalid_o), 0);
        step();
        s_rvalid_i = 5'b00001; s_rdata_i[31:0] = 32'h1234_5678; #1;
        chk("sram_rvalid", 32'(m_rvalid_o), 1);
        chk("sram_rdata", m_rdata_o, 32'h1234_5678);
        chk("sram_err", 32'(m_err_o), 0);
        step(); s_rvalid_i = 0; #1;
        chk("sram_idle", 32'(m_rvalid_o), 0);
        chk("sram_idle_rd", m_rdata_o, 0);
        s_rvalid_i = 5'b00010; #1;
        chk("stray_rvalid", 32'(m_rvalid_o), 0);
        s_rvalid_i = 0;

        // Unmapped read
        m_req_i = 1; m_addr_i = 32'h2000_0000; #1;
        chk("derr_gnt", 32'(m_gnt_o), 1);
        chk("derr_sreq", 32'(s_req_o), 0);
        step(); m_req_i = 0; #1;
        chk("derr_rvalid", 32'(m_rvalid_o), 1);
        chk("derr_rdata", m_rdata_o, 32'hBADC_AB1E);
        chk("derr_err", 32'(m_err_o), 1);
        chk("derr_cnt", 32'(dec_err_cnt_o), 1);
        step();
        chk("derr_done", 32'(m_rvalid_o), 0);

        // Back-to-back SRAM reads, third held until a slot frees
        m_req_i = 1; m_addr_i = 32'h0; #1;
        chk("b2b_gnt0", 32'(m_gnt_o), 1);
        step(); m_addr_i = 32'h4; #1;
        chk("b2b_gnt1", 32'(m_gnt_o), 1);
        step(); m_addr_i = 32'h8; #1;
        chk("b2b_full_gnt", 32'(m_gnt_o), 0);
        chk("b2b_full_sreq", 32'(s_req_o), 0);
        step();
        s_rvalid_i = 5'b00001; s_rdata_i[31:0] = 32'hA; #1;
        chk("b2b_rd_a", m_rdata_o, 32'hA);
        chk("b2b_popgnt", 32'(m_gnt_o), 0);
        step(); s_rdata_i[31:0] = 32'hB; #1;
        chk("b2b_rd_b", m_rdata_o, 32'hB);
        chk("b2b_gnt2", 32'(m_gnt_o), 1);
        step(); m_req_i = 0; s_rdata_i[31:0] = 32'hC; #1;
        chk("b2b_rd_c", m_rdata_o, 32'hC);
        step(); s_rvalid_i = 0; #1;
        chk("b2b_idle", 32'(m_rvalid_o), 0);

        // Target switch blocked while SRAM outstanding
        m_req_i = 1; m_addr_i = 32'h200; #1;
        chk("sw_sram_gnt", 32'(m_gnt_o), 1);
        step(); m_addr_i = 32'h1A33_0004; #1;
        chk("sw_blk_sreq", 32'(s_req_o), 0);
        chk("sw_blk_gnt", 32'(m_gnt_o), 0);
        step();
        s_rvalid_i = 5'b00001; s_rdata_i[31:0] = 32'h55; #1;
        chk("sw_pop_rd", m_rdata_o, 32'h55);
        chk("sw_pop_gnt", 32'(m_gnt_o), 0);
        step(); s_rvalid_i = 0; #1;
        chk("sw_uart_sreq", 32'(s_req_o), 32'b01000);
        chk("sw_uart_gnt", 32'(m_gnt_o), 1);
        step(); m_req_i = 0;
        s_rvalid_i = 5'b01000; s_rdata_i[127:96] = 32'h77;
        s_err_i = 5'b01000; #1;
        chk("sw_uart_rd", m_rdata_o, 32'h77);
        chk("sw_uart_err", 32'(m_err_o), 1);
        step(); s_rvalid_i = 0; s_err_i = 0; #1;

        // Boundary decode, combinational only
        for (int i = 0; i < 9; i++) begin
            m_req_i = 1; m_addr_i = bnd_addr[i]; #1;
            chk($sformatf("bnd%0d_sreq", i), 32'(s_req_o), 32'(bnd_req[i]));
            chk($sformatf("bnd%0d_gnt", i), 32'(m_gnt_o), 32'(bnd_gnt[i]));
            m_req_i = 0;
            step();
        end
        chk("bnd_cnt", 32'(dec_err_cnt_o), 1);

        // Reset with two outstanding, late response dropped
        m_req_i = 1; m_addr_i = 32'h10;
        step(); step();
        rst_i = 1; #1;
        chk("inrst_gnt", 32'(m_gnt_o), 0);
        chk("inrst_sreq", 32'(s_req_o), 0);
        step(); rst_i = 0; m_req_i = 0;
        s_rvalid_i = 5'b00001; s_rdata_i[31:0] = 32'hDEAD; #1;
        chk("late_rvalid", 32'(m_rvalid_o), 0);
        chk("late_rdata", m_rdata_o, 0);
        chk("late_cnt", 32'(dec_err_cnt_o), 0);
        s_rvalid_i = 0;
        m_req_i = 1; m_addr_i = 32'h1A33_0000; #1;
        chk("post_rst_gnt", 32'(m_gnt_o), 1);
        m_req_i = 0;
        step();

        // Saturating decode-error counter
        m_req_i = 1; m_addr_i = 32'hFFFF_FFF0;
        repeat (10) step();
        chk("sat_cnt10", 32'(dec_err_cnt_o), 10);
        repeat (65530) step();
        chk("sat_cnt", 32'(dec_err_cnt_o), 32'hFFFF);
        m_req_i = 0;
        step(); step();
        chk("sat_hold", 32'(dec_err_cnt_o), 32'hFFFF);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
